// File: rtl/pa_tile_buffer.sv
// rtl/pa_tile_buffer.sv - ping-pong tile staging buffer feeding pa_top.
// One bank fills from the write stream while the other drains one vector pair per pop.
module pa_tile_buffer #(
  parameter int SIZE_MAT   = 16,
  parameter int WIDTH_DATA = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_valid_i,
  output logic                           wr_ready_o,
  input  logic [SIZE_MAT*WIDTH_DATA-1:0] wr_v_i,
  input  logic [SIZE_MAT*WIDTH_DATA-1:0] wr_h_i,
  output logic                           data_rdy_o,
  input  logic                           read_en_i,
  output logic [SIZE_MAT*WIDTH_DATA-1:0] v_bus_o,
  output logic [SIZE_MAT*WIDTH_DATA-1:0] h_bus_o,
  output logic                           tile_done_o,
  output logic                           underflow_o,
  output logic [1:0]                     tiles_o
);

  localparam int W_IDX = $clog2(SIZE_MAT);
  localparam int W_VEC = SIZE_MAT * WIDTH_DATA;
  localparam logic [W_IDX-1:0] LAST_IDX = W_IDX'(SIZE_MAT - 1);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

  bank_state_t      state_q [2];
  bank_state_t      state_d [2];
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [W_IDX-1:0] wr_idx_q, wr_idx_d;
  logic [W_IDX-1:0] rd_idx_q, rd_idx_d;

  logic [W_VEC-1:0] mem_v [2][SIZE_MAT];
  logic [W_VEC-1:0] mem_h [2][SIZE_MAT];

  logic accept, pop, last_pop;

  // A bank that holds a committed tile is off limits to the writer until drained.
  assign wr_ready_o = !(state_q[wr_bank_q] inside {FULL, DRAINING});
  assign data_rdy_o = state_q[rd_bank_q] inside {FULL, DRAINING};
  assign accept     = wr_valid_i & wr_ready_o;
  assign pop        = read_en_i & data_rdy_o;
  assign last_pop   = pop && (rd_idx_q == LAST_IDX);
  assign tiles_o    = 2'(state_q[0] inside {FULL, DRAINING}) +
                      2'(state_q[1] inside {FULL, DRAINING});

  always_comb begin
    state_d[0] = state_q[0];
    state_d[1] = state_q[1];
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    // Write and pop always address different banks, so both updates can apply together.
    if (accept) begin
      if (wr_idx_q == LAST_IDX) begin
        state_d[wr_bank_q] = FULL;
        wr_idx_d           = '0;
        wr_bank_d          = ~wr_bank_q;
      end else begin
        state_d[wr_bank_q] = FILLING;
        wr_idx_d           = wr_idx_q + W_IDX'(1);
      end
    end
    if (pop) begin
      if (last_pop) begin
        state_d[rd_bank_q] = EMPTY;
        rd_idx_d           = '0;
        rd_bank_d          = ~rd_bank_q;
      end else begin
        state_d[rd_bank_q] = DRAINING;
        rd_idx_d           = rd_idx_q + W_IDX'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q[0]  <= EMPTY;
      state_q[1]  <= EMPTY;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      v_bus_o     <= '0;
      h_bus_o     <= '0;
      tile_done_o <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      state_q[0]  <= state_d[0];
      state_q[1]  <= state_d[1];
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      tile_done_o <= last_pop;
      if (pop) begin
        v_bus_o <= mem_v[rd_bank_q][rd_idx_q];
        h_bus_o <= mem_h[rd_bank_q][rd_idx_q];
      end
      if (read_en_i && !data_rdy_o) underflow_o <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_v[wr_bank_q][wr_idx_q] <= wr_v_i;
      mem_h[wr_bank_q][wr_idx_q] <= wr_h_i;
    end
  end

endmodule

// File: tb/tb_pa_tile_buffer.sv
// tb/tb_pa_tile_buffer.sv - randomized bench for pa_tile_buffer against a queue model.
module tb_pa_tile_buffer;

  localparam int N = 16;
  localparam int WD = 16;
  localparam int W = N * WD;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_valid = 1'b0;
  logic         wr_ready;
  logic [W-1:0] wr_v = '0;
  logic [W-1:0] wr_h = '0;
  logic         data_rdy;
  logic         read_en = 1'b0;
  logic [W-1:0] v_bus, h_bus;
  logic         tile_done, underflow;
  logic [1:0]   tiles;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  pa_tile_buffer #(.SIZE_MAT(N), .WIDTH_DATA(WD)) dut (
    .clk(clk), .rst(rst),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_v_i(wr_v), .wr_h_i(wr_h),
    .data_rdy_o(data_rdy), .read_en_i(read_en),
    .v_bus_o(v_bus), .h_bus_o(h_bus),
    .tile_done_o(tile_done), .underflow_o(underflow), .tiles_o(tiles)
  );

  // Model: every accepted pair joins a FIFO; committed tiles = whole tiles written minus whole tiles read.
  logic [W-1:0] mq_v[$];
  logic [W-1:0] mq_h[$];
  int           acc = 0;
  int           popped = 0;
  logic [W-1:0] exp_v = '0, exp_h = '0;
  logic         exp_done = 1'b0, exp_under = 1'b0;

  function automatic int committed();
    return acc / N - popped / N;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq_v.delete(); mq_h.delete();
      acc = 0; popped = 0;
      exp_v = '0; exp_h = '0; exp_done = 1'b0; exp_under = 1'b0;
    end else begin
      bit can_wr, can_rd;
      can_wr = committed() < 2;
      can_rd = committed() > 0;
      exp_done = 1'b0;
      if (wr_valid && can_wr) begin
        mq_v.push_back(wr_v); mq_h.push_back(wr_h); acc++;
      end
      if (read_en) begin
        if (can_rd) begin
          exp_v = mq_v.pop_front(); exp_h = mq_h.pop_front(); popped++;
          exp_done = (popped % N) == 0;
        end else begin
          exp_under = 1'b1;
        end
      end
    end
  end

  function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("wr_ready", W'(wr_ready), W'(committed() < 2));
      chk("data_rdy", W'(data_rdy), W'(committed() > 0));
      chk("tiles", W'(tiles), W'(committed()));
      chk("v_bus", v_bus, exp_v);
      chk("h_bus", h_bus, exp_h);
      chk("tile_done", W'(tile_done), W'(exp_done));
      chk("underflow", W'(underflow), W'(exp_under));
      if (tile_done === 1'b1) done_cnt++;
    end
  end

  function automatic logic [W-1:0] mkv(input int base);
    logic [W-1:0] r;
    for (int j = 0; j < N; j++) r[j*WD +: WD] = WD'(base + j);
    return r;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    for (int j = 0; j < W / 32; j++) r[j*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_valid = 1'b0; read_en = 1'b0;
    tick(); tick();
    rst = 1'b0;
    cmp_en = 1'b1;
    done_cnt = 0;
  endtask

  task automatic write_vec(input logic [W-1:0] v, input logic [W-1:0] h);
    int n;
    logic ok;
    n = 0;
    wr_v = v; wr_h = h; wr_valid = 1'b1;
    do begin
      ok = wr_ready;
      tick();
      n++;
    end while (!ok && n < 300);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL write_timeout: got no accept expected accept within 300 cycles");
    end
    wr_valid = 1'b0;
  endtask

  task automatic read_run(input int ncyc, input int period, input bit gate);
    for (int k = 0; k < ncyc; k++) begin
      read_en = (k % period == 0) && (!gate || data_rdy);
      tick();
    end
    read_en = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("reset_tiles", W'(tiles), W'(0));
    chk("reset_wr_ready", W'(wr_ready), W'(1));
    chk("reset_v_bus", v_bus, '0);

    // Single tile with reads requested throughout.
    read_en = 1'b1;
    for (int i = 0; i < N; i++) write_vec(mkv(i), mkv(i + 1000));
    chk("t1_data_rdy_rise", W'(data_rdy), W'(1));
    tick();
    chk("t1_first_pop", v_bus, mkv(0));
    for (int i = 0; i < N + 2; i++) tick();
    read_en = 1'b0;
    chk("t1_last_pop", v_bus, mkv(N - 1));
    chk("t1_done_pulses", W'(done_cnt), W'(1));

    // Two full banks, stalled writer, then back-to-back drain.
    do_reset();
    for (int i = 0; i < N; i++) write_vec(mkv(i), mkv(i + 500));
    for (int i = 0; i < N; i++) write_vec(mkv(100 + i), mkv(600 + i));
    chk("t2_tiles_full", W'(tiles), W'(2));
    chk("t2_wr_ready_low", W'(wr_ready), W'(0));
    wr_v = mkv(200); wr_h = mkv(200); wr_valid = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    wr_valid = 1'b0;
    read_run(2 * N, 1, 1'b0);
    tick();
    chk("t2_last_vec", v_bus, mkv(100 + N - 1));
    chk("t2_done_pulses", W'(done_cnt), W'(2));
    chk("t2_stalled_not_written", W'(tiles), W'(0));

    // Concurrent fill and drain over four random tiles.
    do_reset();
    fork
      for (int i = 0; i < 4 * N; i++) write_vec(rnd(), rnd());
      read_run(6 * N, 1, 1'b1);
    join
    chk("t3_all_drained", W'(popped), W'(4 * N));
    chk("t3_no_underflow", W'(underflow), W'(0));

    // Read from an empty buffer.
    do_reset();
    read_run(2, 1, 1'b0);
    chk("t4_underflow", W'(underflow), W'(1));
    chk("t4_v_hold", v_bus, '0);

    // Sparse reads every third cycle.
    do_reset();
    fork
      for (int i = 0; i < 2 * N; i++) write_vec(rnd(), rnd());
      read_run(3 * 2 * N + 40, 3, 1'b1);
    join
    chk("t5_all_drained", W'(popped), W'(2 * N));

    // Reset in the middle of a fill and a drain.
    do_reset();
    for (int i = 0; i < N; i++) write_vec(mkv(i), mkv(i));
    fork
      for (int i = 0; i < 7; i++) write_vec(mkv(50 + i), mkv(50 + i));
      read_run(3, 1, 1'b0);
    join
    rst = 1'b1;
    tick();
    chk("t6_rst_tiles", W'(tiles), W'(0));
    chk("t6_rst_data_rdy", W'(data_rdy), W'(0));
    chk("t6_rst_wr_ready", W'(wr_ready), W'(1));
    chk("t6_rst_v_bus", v_bus, '0);
    rst = 1'b0;
    for (int i = 0; i < N; i++) write_vec(mkv(100 + i), mkv(300 + i));
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
    chk("t6_first_after_rst", v_bus, mkv(100));
    read_run(N, 1, 1'b0);
    tick();
    chk("t6_last_after_rst", v_bus, mkv(100 + N - 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before 2ms");
    $fatal(1, "timeout");
  end

endmodule
